// File: rtl/vga_capture.sv
// VGA timing capture: measures hsync/vsync timing, locks after consecutive good
// frames, and emits one write strobe per active pixel while locked.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   SEARCH  | waiting for the first anchored line, no timing checks
//   MEASURE | counting consecutive good frames toward lock
//   LOCKED  | timing verified, active pixels are captured
module vga_capture #(
  parameter int   H_TOTAL     = 800,
  parameter int   H_START     = 144,
  parameter int   H_ACTIVE    = 640,
  parameter int   V_TOTAL     = 525,
  parameter int   V_START     = 34,
  parameter int   V_ACTIVE    = 480,
  parameter int   LOCK_FRAMES = 2,
  parameter logic SYNC_ACT    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb,
  output logic       pix_we,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [2:0] pix_rgb,
  output logic       locked,
  output logic       frame_start,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [9:0]  CNT_PRE = 10'd1022;
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
  localparam logic [10:0] H_LO    = 11'(H_START);
  localparam logic [10:0] H_HI    = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_START);
  localparam logic [10:0] V_HI    = 11'(V_START + V_ACTIVE);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  state_t     state, state_next;
  logic       hs_prev, vs_prev;
  logic       anchor_q, anchor_next;
  logic [9:0] hcnt, hcnt_next;
  logic [9:0] vcnt, vcnt_next;
  logic [7:0] good_cnt, good_next;
  logic       h_edge, v_edge, anchored;
  logic       line_err, frame_err, sat_err, timing_err;
  logic       capture;

  always_comb begin
    h_edge      = p_tick && (hsync == SYNC_ACT) && (hs_prev != SYNC_ACT);
    v_edge      = p_tick && (vsync == SYNC_ACT) && (vs_prev != SYNC_ACT);
    anchored    = h_edge && anchor_q;
    hcnt_next   = hcnt;
    vcnt_next   = vcnt;
    anchor_next = anchor_q;
    line_err    = 1'b0;
    frame_err   = 1'b0;
    sat_err     = 1'b0;
    if (p_tick) begin
      if (h_edge) begin
        hcnt_next   = '0;
        anchor_next = 1'b0;
        // Length checks need a previously measured line/frame, so none in SEARCH.
        line_err    = (state != SEARCH) && (({1'b0, hcnt} + 11'd1) != H_TOT);
        if (anchored) begin
          vcnt_next = '0;
          frame_err = (state != SEARCH) && (({1'b0, vcnt} + 11'd1) != V_TOT);
        end else begin
          sat_err = (vcnt == CNT_PRE);
          if (vcnt != CNT_MAX) vcnt_next = vcnt + 10'd1;
        end
      end else begin
        sat_err = (hcnt == CNT_PRE);
        if (hcnt != CNT_MAX) hcnt_next = hcnt + 10'd1;
      end
      if (v_edge) anchor_next = 1'b1;
    end
    timing_err = line_err || frame_err || sat_err;
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    if (timing_err) begin
      state_next = SEARCH;
      good_next  = '0;
    end else if (anchored) begin
      case (state)
        SEARCH: begin
          state_next = MEASURE;
          good_next  = '0;
        end
        MEASURE: begin
          if ((good_cnt + 8'd1) >= LOCK_N) begin
            state_next = LOCKED;
            good_next  = '0;
          end else begin
            good_next = good_cnt + 8'd1;
          end
        end
        LOCKED:  state_next = LOCKED;
        default: state_next = SEARCH;
      endcase
    end
  end

  always_comb begin
    capture = p_tick && (state == LOCKED) && !timing_err &&
              ({1'b0, hcnt_next} >= H_LO) && ({1'b0, hcnt_next} < H_HI) &&
              ({1'b0, vcnt} >= V_LO) && ({1'b0, vcnt} < V_HI);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      hs_prev     <= ~SYNC_ACT;
      vs_prev     <= ~SYNC_ACT;
      anchor_q    <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      good_cnt    <= '0;
      locked      <= 1'b0;
      pix_we      <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      err_cnt     <= '0;
    end else begin
      if (p_tick) begin
        hs_prev <= hsync;
        vs_prev <= vsync;
      end
      hcnt        <= hcnt_next;
      vcnt        <= vcnt_next;
      anchor_q    <= anchor_next;
      state       <= state_next;
      good_cnt    <= good_next;
      locked      <= (state_next == LOCKED);
      pix_we      <= capture;
      frame_start <= anchored && (state_next == LOCKED);
      if (capture) begin
        pix_x   <= hcnt_next - 10'(H_START);
        pix_y   <= vcnt - 10'(V_START);
        pix_rgb <= rgb;
      end
      if (timing_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: a small-geometry synthetic video source with random
// pixel-enable gaps, checked cycle by cycle against a frame-level reference model.
module tb_vga_capture;
  localparam int HT = 20, HS = 5, HA = 10, VT = 12, VS = 3, VA = 6, LF = 2;
  localparam int GAP_MAX = 3;

  logic       clk = 1'b0;
  logic       reset, p_tick, hsync, vsync;
  logic [2:0] rgb;
  logic       pix_we, locked, frame_start;
  logic [9:0] pix_x, pix_y;
  logic [2:0] pix_rgb;
  logic [7:0] err_cnt;

  int checks = 0, errors = 0;

  // reference model: positions in ticks/lines, lock tracked as clean anchors since last error
  int   m_hpos, m_line, m_clean, m_err;
  bit   m_pend, m_hs_prev, m_vs_prev;
  bit   e_we, e_fs, e_locked;
  int   e_x, e_y;
  logic [2:0] e_rgb;

  int src_t, src_l, line_len, lines_done;
  bit pat_mode;

  int n_we, n_fs;
  bit fs_seen, first_got;
  int first_x, first_y, last_x, last_y;
  logic [2:0] first_rgb, last_rgb;

  vga_capture #(
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA),
    .LOCK_FRAMES(LF), .SYNC_ACT(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .locked(locked), .frame_start(frame_start), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hpos = 0; m_line = 0; m_clean = 0; m_err = 0;
    m_pend = 0; m_hs_prev = 0; m_vs_prev = 0;
    e_we = 0; e_fs = 0; e_locked = 0; e_x = 0; e_y = 0; e_rgb = '0;
  endtask

  task automatic model_tick(input bit hs, input bit vs, input logic [2:0] c);
    bit h_edge, v_edge, anch, err;
    int hpos_n, line_n;
    h_edge = hs && !m_hs_prev;
    v_edge = vs && !m_vs_prev;
    anch   = h_edge && m_pend;
    err    = 0;
    line_n = m_line;
    if (h_edge) begin
      if (m_clean > 0 && m_hpos + 1 != HT) err = 1;
      hpos_n = 0;
      if (anch) begin
        if (m_clean > 0 && m_line + 1 != VT) err = 1;
        line_n = 0;
      end else begin
        if (m_line == 1022) err = 1;
        line_n = (m_line >= 1023) ? 1023 : m_line + 1;
      end
    end else begin
      if (m_hpos == 1022) err = 1;
      hpos_n = (m_hpos >= 1023) ? 1023 : m_hpos + 1;
    end
    e_we = (m_clean > LF) && !err && hpos_n >= HS && hpos_n < HS + HA &&
           m_line >= VS && m_line < VS + VA;
    if (e_we) begin
      e_x = hpos_n - HS; e_y = m_line - VS; e_rgb = c;
    end
    if (err) begin
      m_clean = 0;
      if (m_err < 255) m_err++;
    end else if (anch && m_clean <= LF) begin
      m_clean++;
    end
    e_fs     = anch && !err && (m_clean > LF);
    e_locked = (m_clean > LF);
    if (v_edge) m_pend = 1;
    else if (h_edge) m_pend = 0;
    m_hpos = hpos_n; m_line = line_n;
    m_hs_prev = hs; m_vs_prev = vs;
  endtask

  task automatic compare_all();
    chk("pix_we",      32'(pix_we),      32'(e_we));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("locked",      32'(locked),      32'(e_locked));
    chk("err_cnt",     32'(err_cnt),     32'(m_err));
    chk("pix_x",       32'(pix_x),       32'(e_x));
    chk("pix_y",       32'(pix_y),       32'(e_y));
    chk("pix_rgb",     32'(pix_rgb),     32'(e_rgb));
  endtask

  task automatic cyc(input bit tk, input bit hs, input bit vs, input logic [2:0] c);
    @(negedge clk);
    p_tick = tk; hsync = hs; vsync = vs; rgb = c;
    @(posedge clk);
    #1;
    if (tk && reset) model_tick(hs, vs, c);
    else begin e_we = 0; e_fs = 0; end
    compare_all();
    if (pix_we) begin
      n_we++;
      if (fs_seen && !first_got) begin
        first_got = 1; first_x = pix_x; first_y = pix_y; first_rgb = pix_rgb;
      end
      last_x = pix_x; last_y = pix_y; last_rgb = pix_rgb;
    end
    if (frame_start) begin n_fs++; fs_seen = 1; end
  endtask

  task automatic idle();
    cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
  endtask

  task automatic src_tick();
    bit hs, vs;
    logic [2:0] c;
    repeat ($urandom_range(0, GAP_MAX)) idle();
    hs = (src_t < 3);
    vs = (src_l == VT - 1 && src_t >= 10) || (src_l < 2);
    c  = pat_mode ? 3'(src_t - HS) : 3'($urandom_range(0, 7));
    cyc(1'b1, hs, vs, c);
    src_t++;
    if (src_t >= line_len) begin
      src_t = 0; line_len = HT; src_l = (src_l + 1) % VT; lines_done++;
    end
  endtask

  task automatic run_lines(input int n);
    int target;
    target = lines_done + n;
    while (lines_done < target) src_tick();
  endtask

  task automatic run_ticks(input int n);
    repeat (n) src_tick();
  endtask

  task automatic hold_sync(input int n);
    repeat (n) begin
      repeat ($urandom_range(0, GAP_MAX)) idle();
      cyc(1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic window_clear();
    n_we = 0; n_fs = 0; fs_seen = 0; first_got = 0;
    first_x = 0; first_y = 0; last_x = 0; last_y = 0; first_rgb = '0; last_rgb = '0;
  endtask

  task automatic check_zero_outputs();
    chk("rst_pix_we",      32'(pix_we),      32'd0);
    chk("rst_pix_x",       32'(pix_x),       32'd0);
    chk("rst_pix_y",       32'(pix_y),       32'd0);
    chk("rst_pix_rgb",     32'(pix_rgb),     32'd0);
    chk("rst_locked",      32'(locked),      32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_err_cnt",     32'(err_cnt),     32'd0);
  endtask

  initial begin
    reset = 1'b1; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = '0;
    pat_mode = 0;
    src_t = 0; src_l = VT - 1; line_len = HT; lines_done = 0;
    model_reset();
    window_clear();
    #7 reset = 1'b0;
    #1 check_zero_outputs();
    compare_all();
    repeat (2) idle();
    @(negedge clk) reset = 1'b1;

    // acquisition: lock lands on the third anchored line
    run_lines(1);
    run_lines(VT);
    run_lines(VT);
    chk("lock_early", 32'(locked), 32'd0);
    window_clear();
    run_lines(VT);
    chk("lock_3rd", 32'(locked), 32'd1);
    chk("frame_pix_c", 32'(n_we), 32'(HA * VA));
    chk("err_nominal", 32'(err_cnt), 32'd0);

    // column colour pattern: first and last write of a frame
    pat_mode = 1;
    window_clear();
    run_lines(VT);
    pat_mode = 0;
    chk("frame_pix_d", 32'(n_we), 32'(HA * VA));
    chk("fs_count", 32'(n_fs), 32'd1);
    chk("first_x", 32'(first_x), 32'd0);
    chk("first_y", 32'(first_y), 32'd0);
    chk("first_rgb", 32'(first_rgb), 32'd0);
    chk("last_x", 32'(last_x), 32'(HA - 1));
    chk("last_y", 32'(last_y), 32'(VA - 1));
    chk("last_rgb", 32'(last_rgb), 32'((HA - 1) % 8));

    // one line a tick too long while locked
    run_lines(5);
    line_len = HT + 1;
    run_lines(1);
    run_lines(VT - 6);
    chk("long_err", 32'(err_cnt), 32'd1);
    chk("long_unlock", 32'(locked), 32'd0);
    window_clear();
    run_lines(VT);
    run_lines(VT);
    chk("relock_gap", 32'(n_we), 32'd0);
    window_clear();
    run_lines(VT);
    chk("relock_pix", 32'(n_we), 32'(HA * VA));
    chk("relock", 32'(locked), 32'd1);

    // hsync missing for 2000 ticks
    window_clear();
    hold_sync(2000);
    chk("hold_err", 32'(err_cnt), 32'd2);
    chk("hold_we", 32'(n_we), 32'd0);
    chk("hold_lock", 32'(locked), 32'd0);
    run_lines(VT);
    run_lines(VT);
    window_clear();
    run_lines(VT);
    chk("hold_relock_pix", 32'(n_we), 32'(HA * VA));

    // long pixel-enable pause mid-line
    window_clear();
    run_lines(4);
    run_ticks(8);
    repeat (100) idle();
    run_lines(VT - 4);
    chk("pause_pix", 32'(n_we), 32'(HA * VA));
    chk("pause_err", 32'(err_cnt), 32'd2);
    chk("pause_lock", 32'(locked), 32'd1);

    // asynchronous reset in the middle of an active line
    run_lines(5);
    run_ticks(8);
    #2 reset = 1'b0;
    #1 check_zero_outputs();
    model_reset();
    repeat (3) idle();
    @(negedge clk) reset = 1'b1;
    run_lines(VT - 5);
    window_clear();
    run_lines(VT);
    run_lines(VT);
    chk("rst_relock_gap", 32'(n_we), 32'd0);
    chk("rst_relock_early", 32'(locked), 32'd0);
    window_clear();
    run_lines(VT);
    chk("rst_relock_pix", 32'(n_we), 32'(HA * VA));
    chk("rst_relock", 32'(locked), 32'd1);
    chk("rst_relock_err", 32'(err_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_TOTAL 800: pixel ticks per line.
  H_START 144: ticks from hsync leading-edge tick to first active pixel.
  H_ACTIVE 640: active pixels per line.
  V_TOTAL 525: lines per frame.
  V_START 34: vcnt value whose line carries active row 0.
  V_ACTIVE 480: active rows.
  LOCK_FRAMES 2: consecutive good frames needed to lock.
  SYNC_ACT 1: active level of hsync/vsync.
REQ-002 Ports (name, direction, width, meaning):
  clk  in  1: system clock.
  reset  in  1: asynchronous, active-low reset.
  p_tick  in  1: pixel enable, one clk per pixel.
  hsync  in  1: incoming horizontal sync.
  vsync  in  1: incoming vertical sync.
  rgb  in  3: incoming pixel colour.
  pix_we  out  1: one-clk write strobe for a captured active pixel.
  pix_x  out  10: column of the captured pixel.
  pix_y  out  10: row of the captured pixel.
  pix_rgb  out  3: captured colour.
  locked  out  1: timing lock status.
  frame_start  out  1: one-clk pulse at each anchored line while locked.
  err_cnt  out  8: saturating timing-error count.

Function
REQ-003 All logic SHALL advance only on clk edges where p_tick=1; when p_tick=0, counters, FSM and previous-sync registers SHALL hold, and pix_we/frame_start SHALL be 0.
REQ-004 hsync/vsync previous values SHALL be registered each tick; a leading edge SHALL be defined as current=SYNC_ACT and previous!=SYNC_ACT.
REQ-005 hcnt (10 bit) SHALL load 0 on an hsync leading-edge tick, otherwise increment, saturating at 1023.
REQ-006 A vsync leading edge SHALL set an anchor flag; the next hsync leading edge SHALL be the anchored line: vcnt loads 0 and the flag clears. Other hsync edges increment vcnt, saturating at 1023.
REQ-007 Line check: at each hsync edge, hcnt+1 SHALL equal H_TOTAL, otherwise there is a timing error.
REQ-008 Frame check: at each anchored line, vcnt+1 SHALL equal V_TOTAL, otherwise there is a timing error.
REQ-009 A timing error SHALL also be raised once when hcnt or vcnt first reaches 1023; no further error is raised until the next respective edge.
REQ-010 FSM states SHALL be SEARCH, MEASURE and LOCKED, with these transitions:
  SEARCH->MEASURE at the first anchored line; the frame check is skipped.
  MEASURE counts good anchored lines; on the LOCK_FRAMES-th it goes to LOCKED.
  Any state goes to SEARCH on any timing error; the good-frame count clears.
REQ-011 locked SHALL be registered, =1 iff state is LOCKED, and update one clk after the deciding tick.
REQ-012 Capture: when LOCKED on a tick with H_START<=hcnt_next<H_START+H_ACTIVE and V_START<=vcnt<V_START+V_ACTIVE, the module SHALL assert pix_we for one clk on the following edge, with:
  pix_x=hcnt_next-H_START.
  pix_y=vcnt-V_START.
  pix_rgb=rgb sampled on that tick.
REQ-013 Latency SHALL be 1 clk from the sampling tick to pix_we; pix_x/pix_y/pix_rgb SHALL hold between strobes.
REQ-014 frame_start SHALL pulse one clk after an anchored line that leaves the state LOCKED.
REQ-015 err_cnt SHALL increment by 1 per timing error, saturating at 255, and clear only on reset.
REQ-016 If a timing error and a capture condition occur on the same tick, the error SHALL win: no pix_we, and locked falls.

Reset
REQ-017 reset=0 SHALL immediately force all of the following, regardless of clk or p_tick:
  Outputs: pix_we, pix_x, pix_y, pix_rgb, locked, frame_start and err_cnt to 0.
  Internal: hcnt, vcnt, anchor flag and good-frame count to 0; previous-sync registers to !SYNC_ACT; state to SEARCH.
REQ-018 After reset release, the module SHALL require full reacquisition per REQ-010; no partial-frame capture is permitted.

Verification
REQ-019 Nominal 640x480 source, p_tick every 4th clk -> locked=1 one clk after the 3rd anchored line; err_cnt=0; exactly 307200 pix_we per subsequent frame.
REQ-020 Pattern rgb=column[2:0] -> the first write after frame_start is pix_x=0, pix_y=0, pix_rgb=0; the last write is pix_x=639, pix_y=479, pix_rgb=7.
REQ-021 Inject one 801-tick line while locked -> err_cnt=1, locked=0 one clk later, no pix_we until relock two good frames after the next anchor.
REQ-022 Hold hsync inactive for 2000 ticks -> err_cnt increments exactly once, state SEARCH, pix_we stays 0.
REQ-023 Assert reset mid-frame while locked -> all outputs 0 immediately without a clk edge; after release, relock occurs on the 3rd anchored line.
REQ-024 p_tick held low for 100 clks mid-line -> hcnt, vcnt and FSM unchanged; capture resumes at the correct pix_x with no error.
